// File: rtl/freelist_ckpt_pkg.sv
// ---------------------------------------------------------------------------
// freelist_ckpt_pkg
// Shared sizing and pointer helpers for the checkpointed rename free list.
//   WAYS     : dispatch / retire channels per cycle
//   PR_NUM   : physical registers (tag width PRW)
//   ARCH_NUM : architectural registers; the free list holds the rest (DEPTH)
//   CKPT     : branch checkpoint slots (slot id width CKW)
// A pointer is an index into the DEPTH-entry ring plus a wrap bit. The wrap
// bit toggles on every pass so equal indices still tell full from empty.
// ---------------------------------------------------------------------------
package freelist_ckpt_pkg;

  localparam int WAYS     = 3;
  localparam int PR_NUM   = 64;
  localparam int ARCH_NUM = 32;
  localparam int CKPT     = 4;

  localparam int DEPTH = PR_NUM - ARCH_NUM;
  localparam int PRW   = $clog2(PR_NUM);
  localparam int CKW   = $clog2(CKPT);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int WCW   = $clog2(WAYS + 1);
  localparam int SUMW  = CNTW + 1;

  typedef logic [PRW-1:0] tag_t;

  typedef struct packed {
    logic            wrap;
    logic [IDXW-1:0] idx;
  } ptr_t;

  // Advance a pointer by n (n <= DEPTH), wrapping the index modulo DEPTH
  // and toggling the wrap bit when the ring boundary is crossed.
  function automatic ptr_t ptr_add(ptr_t p, logic [CNTW-1:0] n);
    logic [SUMW-1:0] sum;
    ptr_t            r;
    sum = SUMW'(p.idx) + SUMW'(n);
    if (sum >= SUMW'(DEPTH)) begin
      r.idx  = IDXW'(sum - SUMW'(DEPTH));
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = IDXW'(sum);
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  // Number of ring entries from b up to a (a is never more than one lap ahead).
  function automatic logic [CNTW-1:0] ptr_diff(ptr_t a, ptr_t b);
    if (a.wrap == b.wrap)
      return CNTW'(a.idx) - CNTW'(b.idx);
    else
      return CNTW'(DEPTH) - CNTW'(b.idx) + CNTW'(a.idx);
  endfunction

  function automatic logic [CNTW-1:0] ways_popcount(logic [WAYS-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < WAYS; i++)
      c = c + CNTW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/freelist_compact.sv
// ---------------------------------------------------------------------------
// freelist_compact
// Packs a sparse set of enabled lanes into a dense, way-ordered vector.
//   en    : lane enables, any bit pattern
//   data  : per-lane payload
//   dense : enabled payloads in lane order starting at dense[0];
//           slots at and above count are zero
//   count : number of enabled lanes
// Purely combinational so it can sit in front of any ring write port
// (free list release, ROB allocate).
// ---------------------------------------------------------------------------
module freelist_compact #(
  parameter int WAYS = 3,
  parameter int W    = 6
) (
  input  logic [WAYS-1:0]                 en,
  input  logic [WAYS-1:0][W-1:0]          data,
  output logic [WAYS-1:0][W-1:0]          dense,
  output logic [$clog2(WAYS+1)-1:0]       count
);

  localparam int CW = $clog2(WAYS + 1);

  // Each enabled lane lands at the number of enabled lanes below it.
  always_comb begin
    logic [CW-1:0] c;
    c     = '0;
    dense = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (en[i]) begin
        dense[c] = data[i];
        c        = c + CW'(1);
      end
    end
    count = c;
  end

endmodule

// File: rtl/freelist_ckpt.sv
// ---------------------------------------------------------------------------
// freelist_ckpt
// Circular free list of physical register tags with WAYS-wide allocate,
// WAYS-wide release and CKPT branch checkpoints of the head pointer.
//   clock, reset  : posedge clock, synchronous active-high reset
//   dispatch_en   : thermometer of ways consuming free_reg this cycle
//   free_reg      : tags at head, head+1, ... (valid where free_valid)
//   free_valid    : bit i set when more than i tags are free
//   free_count    : tags currently free
//   retire_en/reg : tags returned by retire, any enable pattern
//   ckpt_take/id  : save the post-allocation head into a slot
//   recover_en/id : restore head from a slot, discarding this cycle's dispatch
// ---------------------------------------------------------------------------
module freelist_ckpt
  import freelist_ckpt_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WAYS-1:0]            dispatch_en,
  output logic [WAYS-1:0][PRW-1:0]   free_reg,
  output logic [WAYS-1:0]            free_valid,
  output logic [CNTW-1:0]            free_count,
  input  logic [WAYS-1:0]            retire_en,
  input  logic [WAYS-1:0][PRW-1:0]   retire_reg,
  input  logic                       ckpt_take,
  input  logic [CKW-1:0]             ckpt_id,
  input  logic                       recover_en,
  input  logic [CKW-1:0]             recover_id
);

  tag_t entry [DEPTH];
  ptr_t slot  [CKPT];
  ptr_t head, tail, head_next, tail_next;

  logic [CNTW-1:0]            consumed;
  logic [WAYS-1:0][PRW-1:0]   ret_dense;
  logic [WCW-1:0]             ret_count;
  logic [IDXW-1:0]            wr_idx [WAYS];

  freelist_compact #(
    .WAYS (WAYS),
    .W    (PRW)
  ) u_compact (
    .en    (retire_en),
    .data  (retire_reg),
    .dense (ret_dense),
    .count (ret_count)
  );

  assign free_count = ptr_diff(tail, head);

  // Offer the next WAYS tags straight from storage; released tags only
  // become visible once tail has moved, i.e. the following cycle.
  always_comb begin
    ptr_t rd_ptr;
    rd_ptr     = head;
    free_reg   = '0;
    free_valid = '0;
    for (int i = 0; i < WAYS; i++) begin
      rd_ptr        = ptr_add(head, CNTW'(i));
      free_reg[i]   = entry[rd_ptr.idx];
      free_valid[i] = (free_count > CNTW'(i));
    end
  end

  // Requests beyond the available tags are masked, so head never passes tail.
  assign consumed = ways_popcount(dispatch_en & free_valid);

  // Recover rewinds head and throws away this cycle's dispatch; release
  // always advances tail.
  always_comb begin
    ptr_t wp;
    if (recover_en)
      head_next = slot[recover_id];
    else
      head_next = ptr_add(head, consumed);
    tail_next = ptr_add(tail, CNTW'(ret_count));
    wp        = tail;
    for (int k = 0; k < WAYS; k++) begin
      wp        = ptr_add(tail, CNTW'(k));
      wr_idx[k] = wp.idx;
    end
  end

  // State update. Reset reloads the ring with the tags above the
  // architectural range and puts tail one full lap ahead of head.
  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail.wrap <= 1'b1;
      tail.idx  <= '0;
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= PRW'(ARCH_NUM + i);
      for (int s = 0; s < CKPT; s++)
        slot[s] <= '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      if (ckpt_take && !recover_en)
        slot[ckpt_id] <= head_next;
      for (int k = 0; k < WAYS; k++)
        if (WCW'(k) < ret_count)
          entry[wr_idx[k]] <= ret_dense[k];
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: releasing more tags than the ring holds, and
  // (in test builds) a dispatch mask with holes in it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ((SUMW'(free_count) + SUMW'(ret_count)) <= SUMW'(DEPTH))
        else $error("freelist_ckpt: release overflows free list");
`ifdef TEST_MODE
      assert ((dispatch_en & (dispatch_en + WAYS'(1))) == '0)
        else $error("freelist_ckpt: dispatch_en is not a thermometer code");
`endif
    end
  end
`endif

endmodule

// File: tb/tb_freelist_ckpt.sv
// ---------------------------------------------------------------------------
// tb_freelist_ckpt
// Directed bench for freelist_ckpt. A small behavioural model (unbounded
// head/tail counters over a DEPTH-entry array) produces the expected
// outputs for every step; they go into a scoreboard queue and are popped
// and compared after the clock edge. Extra constant checks pin down the
// key values of each scenario.
// ---------------------------------------------------------------------------
module tb_freelist_ckpt;
  import freelist_ckpt_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [WAYS-1:0]           dispatch_en = '0;
  logic [WAYS-1:0][PRW-1:0]  free_reg;
  logic [WAYS-1:0]           free_valid;
  logic [CNTW-1:0]           free_count;
  logic [WAYS-1:0]           retire_en = '0;
  logic [WAYS-1:0][PRW-1:0]  retire_reg = '0;
  logic                      ckpt_take = 1'b0;
  logic [CKW-1:0]            ckpt_id = '0;
  logic                      recover_en = 1'b0;
  logic [CKW-1:0]            recover_id = '0;

  always #5 clock = ~clock;

  freelist_ckpt dut (
    .clock       (clock),
    .reset       (reset),
    .dispatch_en (dispatch_en),
    .free_reg    (free_reg),
    .free_valid  (free_valid),
    .free_count  (free_count),
    .retire_en   (retire_en),
    .retire_reg  (retire_reg),
    .ckpt_take   (ckpt_take),
    .ckpt_id     (ckpt_id),
    .recover_en  (recover_en),
    .recover_id  (recover_id)
  );

  typedef struct {
    string                    tag;
    int                       cnt;
    logic [WAYS-1:0]          vld;
    logic [WAYS-1:0][PRW-1:0] regs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   mem [DEPTH];
  int   mhead;
  int   mtail;
  int   mslot [CKPT];

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_expect(input string tag);
    exp_t e;
    e.tag  = tag;
    e.cnt  = mtail - mhead;
    e.vld  = '0;
    e.regs = '0;
    for (int i = 0; i < WAYS; i++) begin
      e.vld[i] = (e.cnt > i);
      if (e.vld[i]) e.regs[i] = PRW'(mem[(mhead + i) % DEPTH]);
    end
    return e;
  endfunction

  task automatic model_step(input logic rst, input logic [WAYS-1:0] disp,
                            input logic [WAYS-1:0] ren,
                            input logic [WAYS-1:0][PRW-1:0] rreg,
                            input logic take, input logic [CKW-1:0] tid,
                            input logic rec, input logic [CKW-1:0] rid);
    int cnt;
    int used;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = ARCH_NUM + i;
      for (int s = 0; s < CKPT; s++) mslot[s] = 0;
      mhead = 0;
      mtail = DEPTH;
    end else begin
      cnt  = mtail - mhead;
      used = 0;
      for (int i = 0; i < WAYS; i++)
        if (disp[i] && i < cnt) used++;
      if (rec) mhead = mslot[rid];
      else begin
        mhead = mhead + used;
        if (take) mslot[tid] = mhead;
      end
      for (int i = 0; i < WAYS; i++)
        if (ren[i]) begin
          mem[mtail % DEPTH] = int'(rreg[i]);
          mtail++;
        end
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check_val({e.tag, ".count"}, int'(free_count), e.cnt);
      check_val({e.tag, ".valid"}, int'(free_valid), int'(e.vld));
      for (int i = 0; i < WAYS; i++)
        if (e.vld[i])
          check_val($sformatf("%s.reg%0d", e.tag, i), int'(free_reg[i]), int'(e.regs[i]));
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic apply_stimulus(input string tag, input logic rst,
                                input logic [WAYS-1:0] disp,
                                input logic [WAYS-1:0] ren,
                                input logic [WAYS-1:0][PRW-1:0] rreg,
                                input logic take, input logic [CKW-1:0] tid,
                                input logic rec, input logic [CKW-1:0] rid);
    reset       = rst;
    dispatch_en = disp;
    retire_en   = ren;
    retire_reg  = rreg;
    ckpt_take   = take;
    ckpt_id     = tid;
    recover_en  = rec;
    recover_id  = rid;
    model_step(rst, disp, ren, rreg, take, tid, rec, rid);
    sb.push_back(model_expect(tag));
    @(posedge clock);
    #1;
    reset       = 1'b0;
    dispatch_en = '0;
    retire_en   = '0;
    retire_reg  = '0;
    ckpt_take   = 1'b0;
    ckpt_id     = '0;
    recover_en  = 1'b0;
    recover_id  = '0;
    check_output();
  endtask

  task automatic check_reset_view(input string tag);
    check_val({tag, ".count"}, int'(free_count), 32);
    check_val({tag, ".valid"}, int'(free_valid), 7);
    check_val({tag, ".reg0"}, int'(free_reg[0]), 32);
    check_val({tag, ".reg1"}, int'(free_reg[1]), 33);
    check_val({tag, ".reg2"}, int'(free_reg[2]), 34);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Scenario 1: reset then idle
    #2;
    apply_stimulus("rst", 1'b1, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    apply_stimulus("idle", 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    check_reset_view("s1");

    // Scenario 2: drain with full-width dispatch
    for (int k = 0; k < 10; k++)
      apply_stimulus("drain", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    check_val("s2.count", int'(free_count), 2);
    check_val("s2.valid", int'(free_valid), 3);
    check_val("s2.reg0", int'(free_reg[0]), 62);
    check_val("s2.reg1", int'(free_reg[1]), 63);
    apply_stimulus("drain_last", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    check_val("s2.empty_count", int'(free_count), 0);
    check_val("s2.empty_valid", int'(free_valid), 0);

    // Scenario 3: release into an empty list, no bypass
    retire_en  = 3'b001;
    retire_reg = {6'd0, 6'd0, 6'd1};
    #1;
    check_val("s3.nobypass_valid", int'(free_valid), 0);
    check_val("s3.nobypass_count", int'(free_count), 0);
    apply_stimulus("rel1", 1'b0, '0, 3'b001, {6'd0, 6'd0, 6'd1}, 1'b0, '0, 1'b0, '0);
    check_val("s3.reg0", int'(free_reg[0]), 1);
    check_val("s3.count1", int'(free_count), 1);
    apply_stimulus("rel101", 1'b0, '0, 3'b101, {6'd7, 6'd9, 6'd5}, 1'b0, '0, 1'b0, '0);
    check_val("s3.count3", int'(free_count), 3);
    check_val("s3.reg1", int'(free_reg[1]), 5);
    check_val("s3.reg2", int'(free_reg[2]), 7);

    // Scenario 4: checkpoint and recover
    apply_stimulus("rst4", 1'b1, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    apply_stimulus("take2", 1'b0, 3'b111, '0, '0, 1'b1, 2'd2, 1'b0, '0);
    apply_stimulus("disp4a", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    apply_stimulus("disp4b", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    check_val("s4.count23", int'(free_count), 23);
    apply_stimulus("recover2", 1'b0, 3'b111, 3'b011, {6'd0, 6'd11, 6'd10}, 1'b1, 2'd0, 1'b1, 2'd2);
    check_val("s4.count31", int'(free_count), 31);
    check_val("s4.reg0", int'(free_reg[0]), 35);
    check_val("s4.reg1", int'(free_reg[1]), 36);
    check_val("s4.reg2", int'(free_reg[2]), 37);

    // Scenario 5: wrap around the ring
    apply_stimulus("rst5", 1'b1, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 11; k++)
      apply_stimulus("w_drain", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 10; k++)
      apply_stimulus("w_rel", 1'b0, '0, 3'b111,
                     {PRW'(3*k+3), PRW'(3*k+2), PRW'(3*k+1)}, 1'b0, '0, 1'b0, '0);
    apply_stimulus("w_rel_last", 1'b0, '0, 3'b011, {6'd0, 6'd32, 6'd31}, 1'b0, '0, 1'b0, '0);
    check_val("s5.full", int'(free_count), 32);
    for (int k = 0; k < 10; k++)
      apply_stimulus("w_disp", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    apply_stimulus("w_rel3", 1'b0, '0, 3'b111, {6'd42, 6'd41, 6'd40}, 1'b0, '0, 1'b0, '0);
    check_val("s5.edge_reg0", int'(free_reg[0]), 31);
    check_val("s5.edge_reg1", int'(free_reg[1]), 32);
    check_val("s5.edge_reg2", int'(free_reg[2]), 40);
    apply_stimulus("w_cross", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    check_val("s5.cross_count", int'(free_count), 2);
    check_val("s5.cross_reg0", int'(free_reg[0]), 41);
    check_val("s5.cross_reg1", int'(free_reg[1]), 42);

    // Scenario 6: reset in the middle of activity clears checkpoints
    apply_stimulus("take1", 1'b0, 3'b111, '0, '0, 1'b1, 2'd1, 1'b0, '0);
    apply_stimulus("busy", 1'b0, 3'b001, 3'b110, {6'd50, 6'd51, 6'd0}, 1'b0, '0, 1'b0, '0);
    apply_stimulus("rst_mid", 1'b1, 3'b111, 3'b111, {6'd3, 6'd2, 6'd1}, 1'b1, 2'd1, 1'b1, 2'd1);
    check_reset_view("s6");
    apply_stimulus("disp6", 1'b0, 3'b111, '0, '0, 1'b0, '0, 1'b0, '0);
    apply_stimulus("recover1", 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 2'd1);
    check_reset_view("s6.slot");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freelist_ckpt.md
Name: freelist_ckpt

Overview:
- Parametrised successor to the rename-stage free list: a circular FIFO of free physical register tags with N-way allocate at dispatch and N-way release at retire.
- Adds multi-slot branch checkpoints. A checkpoint snapshots the head pointer; a recover restores it in one cycle, so mispredicted allocations return to the pool.
- Sits between dispatch/rename (consumer of free_reg) and ROB retire (producer of retire_reg). The branch unit drives checkpoint take/recover.

Parameters:
- WAYS, 3, dispatch/retire channels per cycle
- PR_NUM, 64, physical registers; PRW = $clog2(PR_NUM)
- ARCH_NUM, 32, architectural registers; DEPTH = PR_NUM - ARCH_NUM
- CKPT, 4, checkpoint slots; CKW = $clog2(CKPT)

Ports:
- clock  in  1  single clock, posedge
- reset  in  1  synchronous, active-high
- dispatch_en  in  WAYS  consume way i this cycle; thermometer from bit 0
- free_reg  out  WAYS x PRW  tags offered at head, head+1, ...
- free_valid  out  WAYS  bit i = (free_count > i)
- free_count  out  $clog2(DEPTH+1)  entries currently free
- retire_en  in  WAYS  release retire_reg[i]; any bit pattern allowed
- retire_reg  in  WAYS x PRW  tags being freed
- ckpt_take  in  1  snapshot post-dispatch head into slot ckpt_id
- ckpt_id  in  CKW  slot for take
- recover_en  in  1  restore head from slot recover_id
- recover_id  in  CKW  slot for recover

Behaviour:
- Storage: DEPTH x PRW array. head and tail pointers are $clog2(DEPTH)+1 bits, the MSB being the wrap bit. free_count = tail - head.
- Reset (synchronous, overrides everything, including mid-operation):
  - entry[i] = ARCH_NUM + i; head = 0; tail = DEPTH (index 0, wrap bit 1); free_count = DEPTH.
  - All checkpoint slots = 0.
  - free_valid is all ones when DEPTH >= WAYS.
- Outputs:
  - free_reg[i] = entry[(head+i) mod DEPTH], read combinationally from registers. Zero added cycles of latency: a tag offered in cycle t is consumed at the posedge ending t.
  - free_reg is don't-care where free_valid is 0.
- Allocate:
  - consumed = popcount(dispatch_en & free_valid); head += consumed.
  - Ways requested without free_valid are ignored (no underflow).
  - A non-thermometer dispatch_en is an assertion failure in TEST_MODE.
- Release:
  - Enabled retire_reg values are compacted in way order and written to tail, tail+1, ...; tail += popcount(retire_en).
  - Released tags are not bypassed to free_reg; they are first offered the next cycle.
  - Release when free_count + popcount(retire_en) > DEPTH is an assertion failure; the write is still performed.
- Wrap: indices wrap modulo DEPTH; the wrap bit toggles, so full and empty are unambiguous.
- Checkpoint: on ckpt_take, slot[ckpt_id] <= head_next (the head after this cycle's allocation). A retake overwrites the slot.
- Recover:
  - On recover_en, head <= slot[recover_id]. dispatch_en is ignored that cycle. Retires that cycle still apply to tail.
  - free_count next = tail_next - restored head.
  - ckpt_take in the same cycle is ignored.
- Priority: reset > recover > (allocate, release, take).

Decomposition:
- Shared package: DEPTH, PRW and CKW derivations, plus the pointer typedef (index + wrap bit).
- Sub-module freelist_compact: a WAYS-input compaction network that maps a sparse retire_en/retire_reg onto a dense write vector and count. It is also reusable by the ROB.

Test Plan:
1. Reset, then idle one cycle -> free_reg={32,33,34}, free_valid=111, free_count=32.
2. dispatch_en=111 for 10 cycles -> head=30, free_count=2, free_valid=011, free_reg[1:0]={63,62}. One more 111 cycle consumes 2 -> free_count=0, free_valid=000.
3. At free_count=0: retire_en=001, retire_reg[0]=1 -> same cycle free_valid=000; next cycle free_reg[0]=1, free_count=1. retire_en=101 with regs {5,x,7} -> entries written as 5,7 in that order, free_count +2.
4. From reset:
   - dispatch 111 with ckpt_take, ckpt_id=2 -> slot2=3.
   - Dispatch 111 twice -> head=9, free_count=23.
   - recover_en, recover_id=2 with retire_en=011 and dispatch_en=111 -> head=3, free_count=31, free_reg={35,36,37}; dispatch ignored.
5. Wrap: drain 32, release 32 (tags 1..32), then dispatch 111 across index 31->0 -> contiguous correct tags, wrap bit toggled, free_count exact.
6. Reset asserted mid-sequence with dispatch/retire/recover active -> next cycle matches scenario 1 exactly, checkpoint slots = 0.
